psx_pad_responder: RTL and testbench

- Device-side (pad) end of the PlayStation/DualShock serial link; emulates a controller for a host poller such as dualshock_controller.
- Oversamples the host's psCLK/psSEL/psTXD on the system clock and shifts back a poll reply (LSB first) on O_psRXD.
- Pulses O_psACK_n after each non-final byte.
- Used for bench loopback against the host block and as a pad emulator on an FPGA-to-console board.

---
 rtl/psx_pad_pkg.sv | 37 +++
 rtl/psx_edge_sync.sv | 48 ++++
 rtl/psx_pad_responder.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_psx_pad_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_pad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psx_pad_pkg
//  Description : Shared constants, state encoding and helpers for the
//                PlayStation pad responder (device side of the pad link).
//                Holds the protocol byte values, the responder state enum
//                and the final-byte index lookup used by the top level.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package psx_pad_pkg;

    // Protocol byte values seen on the wire
    localparam logic [7:0] PSX_CMD_START  = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_ID_ANALOG  = 8'h73;
    localparam logic [7:0] PSX_DATA_MARK  = 8'h5A;
    localparam logic [7:0] PSX_IDLE_BYTE  = 8'hFF;

    // Index of the last byte of a frame in each mode
    localparam logic [3:0] PSX_LAST_DIGITAL = 4'd4;
    localparam logic [3:0] PSX_LAST_ANALOG  = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        IGNORE = 2'd2,
        DONE   = 2'd3
    } psx_state_t;

    function automatic logic [3:0] psx_last_byte(input logic analog);
        return analog ? PSX_LAST_ANALOG : PSX_LAST_DIGITAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psx_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : psx_edge_sync
//  Description : Two-flop synchronizer for one asynchronous pad-link line,
//                plus single-cycle rise/fall pulses derived by comparing the
//                synchronized level with its value one cycle earlier.
//  Ports       : clk       - system clock
//                rst_n     - synchronous active-low reset
//                async_in  - asynchronous input pin
//                sync_out  - synchronized level
//                rise      - one-cycle pulse on a synchronized 0->1
//                fall      - one-cycle pulse on a synchronized 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module psx_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // During reset the whole chain tracks the pin, so releasing reset while a
    // line already sits low (e.g. SEL held through a mid-frame reset) does not
    // manufacture a false edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= async_in;
            r_sync <= async_in;
            r_prev <= async_in;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync_out = r_sync;
    assign rise     = r_sync & ~r_prev;
    assign fall     = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/psx_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module      : psx_pad_responder
//  Description : Device-side PlayStation/DualShock pad emulator. Oversamples
//                the host psCLK/psSEL/psTXD lines, shifts back a poll reply
//                LSB first on O_psRXD and pulses O_psACK_n after every
//                non-final byte. Captures host bytes 3/4 of a 0x42 poll as
//                vibration data.
//  Ports       : I_CLK        - system clock
//                I_RSTn       - synchronous active-low reset
//                I_psCLK      - host serial clock (async, idle high)
//                I_psSEL      - host select, active-low (async)
//                I_psTXD      - host command data (async)
//                O_psRXD      - reply data, idles high
//                O_psACK_n    - acknowledge, active-low
//                I_ANALOG     - 1 = analog (ID 0x73, 9 bytes), 0 = digital
//                I_BTN        - button bytes, active-low, [7:0] first
//                I_STICK      - RX, RY, LX, LY from [7:0] upward
//                O_VIB        - host bytes 3/4 of the last completed poll
//                O_FRAME_DONE - one-cycle pulse at end of a valid frame
//  Revision    : 1.0 - initial release
// ============================================================================
module psx_pad_responder
    import psx_pad_pkg::*;
#(
    parameter int ACK_DELAY = 126,
    parameter int ACK_WIDTH = 50
) (
    input  logic        I_CLK,
    input  logic        I_RSTn,
    input  logic        I_psCLK,
    input  logic        I_psSEL,
    input  logic        I_psTXD,
    output logic        O_psRXD,
    output logic        O_psACK_n,
    input  logic        I_ANALOG,
    input  logic [15:0] I_BTN,
    input  logic [31:0] I_STICK,
    output logic [15:0] O_VIB,
    output logic        O_FRAME_DONE
);

    localparam int C_ACK_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int C_CNT_W   = $clog2(C_ACK_MAX + 1);
    localparam logic [C_CNT_W-1:0] C_DELAY_LOAD = C_CNT_W'(ACK_DELAY - 1);
    localparam logic [C_CNT_W-1:0] C_WIDTH_LOAD = C_CNT_W'(ACK_WIDTH - 1);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic w_clk_lvl, w_clk_rise, w_clk_fall;
    logic w_sel,     w_sel_rise, w_sel_fall;
    logic w_txd,     w_txd_rise, w_txd_fall;

    psx_edge_sync u_sync_clk (
        .clk      (I_CLK),
        .rst_n    (I_RSTn),
        .async_in (I_psCLK),
        .sync_out (w_clk_lvl),
        .rise     (w_clk_rise),
        .fall     (w_clk_fall)
    );

    psx_edge_sync u_sync_sel (
        .clk      (I_CLK),
        .rst_n    (I_RSTn),
        .async_in (I_psSEL),
        .sync_out (w_sel),
        .rise     (w_sel_rise),
        .fall     (w_sel_fall)
    );

    psx_edge_sync u_sync_txd (
        .clk      (I_CLK),
        .rst_n    (I_RSTn),
        .async_in (I_psTXD),
        .sync_out (w_txd),
        .rise     (w_txd_rise),
        .fall     (w_txd_fall)
    );

    // SEL is acted on by level (a high level in any active state means it
    // has just risen); the remaining edge/level taps are not needed.
    logic w_unused_sync;
    assign w_unused_sync = ^{w_clk_lvl, w_sel_rise, w_txd_rise, w_txd_fall};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    psx_state_t r_state;
    psx_state_t w_next_state;

    logic        r_mode;
    logic [7:0]  r_tx;
    logic [6:0]  r_rx;
    logic [3:0]  r_byte_idx;
    logic [2:0]  r_bit_idx;
    logic [15:0] r_btn_snap;
    logic [31:0] r_stick_snap;
    logic [15:0] r_staging;
    logic        r_rxd;
    logic [15:0] r_vib;
    logic        r_frame_done;

    logic               r_ack_busy;
    logic               r_ack_low;
    logic [C_CNT_W-1:0] r_ack_cnt;

    // ------------------------------------------------------------------
    // Byte-completion decode
    // ------------------------------------------------------------------
    logic       w_byte_done;
    logic [7:0] w_rx_byte;
    logic       w_final;
    logic       w_bad;
    logic       w_arm;
    logic [7:0] w_next_tx;
    logic [15:0] w_vib_final;

    // SEL high takes priority, so a psCLK rise coincident with SEL rise
    // never samples a bit.
    assign w_byte_done = (r_state == XFER) && !w_sel && w_clk_rise
                         && (r_bit_idx == 3'd7);
    assign w_rx_byte   = {w_txd, r_rx};
    assign w_final     = w_byte_done && (r_byte_idx == psx_last_byte(r_mode));
    assign w_bad       = w_byte_done &&
                         (((r_byte_idx == 4'd0) && (w_rx_byte != PSX_CMD_START)) ||
                          ((r_byte_idx == 4'd1) && (w_rx_byte != PSX_CMD_POLL)));
    assign w_arm       = w_byte_done && !w_bad && !w_final;

    // Digital frames end on byte 4, whose host value is still on the wire;
    // analog frames already have both bytes in staging.
    assign w_vib_final = (r_byte_idx == 4'd4) ? {w_rx_byte, r_staging[7:0]}
                                               : r_staging;

    // Reply byte for the byte following the one just completed
    always_comb begin
        w_next_tx = PSX_IDLE_BYTE;
        case (r_byte_idx)
            4'd0:    w_next_tx = r_mode ? PSX_ID_ANALOG : PSX_ID_DIGITAL;
            4'd1:    w_next_tx = PSX_DATA_MARK;
            4'd2:    w_next_tx = r_btn_snap[7:0];
            4'd3:    w_next_tx = r_btn_snap[15:8];
            4'd4:    w_next_tx = r_stick_snap[7:0];
            4'd5:    w_next_tx = r_stick_snap[15:8];
            4'd6:    w_next_tx = r_stick_snap[23:16];
            4'd7:    w_next_tx = r_stick_snap[31:24];
            default: w_next_tx = PSX_IDLE_BYTE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_sel_fall) begin
                    w_next_state = XFER;
                end
            end
            XFER: begin
                if (w_sel) begin
                    w_next_state = IDLE;
                end else if (w_bad) begin
                    w_next_state = IGNORE;
                end else if (w_final) begin
                    w_next_state = DONE;
                end
            end
            IGNORE, DONE: begin
                if (w_sel) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift datapath, snapshots and vibration capture
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            r_mode       <= 1'b0;
            r_tx         <= PSX_IDLE_BYTE;
            r_rx         <= '0;
            r_byte_idx   <= '0;
            r_bit_idx    <= '0;
            r_btn_snap   <= '0;
            r_stick_snap <= '0;
            r_staging    <= '0;
            r_rxd        <= 1'b1;
            r_vib        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rxd <= 1'b1;
                    if (w_sel_fall) begin
                        r_mode     <= I_ANALOG;
                        r_tx       <= PSX_IDLE_BYTE;
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                    end
                end
                XFER: begin
                    if (w_sel) begin
                        r_rxd <= 1'b1;
                    end else begin
                        if (w_clk_fall) begin
                            r_rxd <= r_tx[r_bit_idx];
                        end
                        if (w_clk_rise) begin
                            // Bit 7 is taken straight from the line at completion
                            if (r_bit_idx != 3'd7) begin
                                r_rx[r_bit_idx] <= w_txd;
                            end
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                        if (w_byte_done) begin
                            if (r_byte_idx != PSX_LAST_ANALOG) begin
                                r_byte_idx <= r_byte_idx + 4'd1;
                            end
                            if (w_bad) begin
                                r_rxd <= 1'b1;
                            end else if (w_final) begin
                                r_rxd        <= 1'b1;
                                r_frame_done <= 1'b1;
                                r_vib        <= w_vib_final;
                            end else begin
                                r_tx <= w_next_tx;
                                // Freeze pad state once the poll is confirmed so
                                // every reply byte of the frame is coherent.
                                if (r_byte_idx == 4'd1) begin
                                    r_btn_snap   <= I_BTN;
                                    r_stick_snap <= I_STICK;
                                end
                                if (r_byte_idx == 4'd3) begin
                                    r_staging[7:0] <= w_rx_byte;
                                end
                                if (r_byte_idx == 4'd4) begin
                                    r_staging[15:8] <= w_rx_byte;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_rxd <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ACK generator: ACK_DELAY cycles of wait then ACK_WIDTH cycles low.
    // Only SEL going high, leaving the active frame or a rejected byte
    // cancels it; further psCLK activity does not.
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            r_ack_busy <= 1'b0;
            r_ack_low  <= 1'b0;
            r_ack_cnt  <= '0;
        end else if (w_sel || (r_state == IDLE) || (r_state == IGNORE) ||
                     (w_byte_done && w_bad)) begin
            r_ack_busy <= 1'b0;
            r_ack_low  <= 1'b0;
            r_ack_cnt  <= '0;
        end else if (w_arm) begin
            r_ack_busy <= 1'b1;
            r_ack_low  <= 1'b0;
            r_ack_cnt  <= C_DELAY_LOAD;
        end else if (r_ack_busy) begin
            if (r_ack_cnt == '0) begin
                if (!r_ack_low) begin
                    r_ack_low <= 1'b1;
                    r_ack_cnt <= C_WIDTH_LOAD;
                end else begin
                    r_ack_busy <= 1'b0;
                    r_ack_low  <= 1'b0;
                end
            end else begin
                r_ack_cnt <= r_ack_cnt - 1'b1;
            end
        end
    end

    assign O_psRXD      = r_rxd;
    assign O_psACK_n    = ~r_ack_low;
    assign O_VIB        = r_vib;
    assign O_FRAME_DONE = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_psx_pad_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psx_pad_responder
//  Description : Self-checking bench for psx_pad_responder. A host model
//                drives psCLK/psSEL/psTXD; expected replies, ACK timing,
//                frame-done pulses and vibration values come from a
//                frame-level reference model of the pad protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psx_pad_responder;

    localparam int ACK_DELAY = 126;
    localparam int ACK_WIDTH = 50;
    localparam int HALF      = 8;
    // Pin change to registered response is 3 system cycles; ACK then starts
    // ACK_DELAY cycles after the byte is registered complete.
    localparam int ACK_LAT   = ACK_DELAY + 3;
    localparam int NONE      = 99;

    logic        clk;
    logic        rst_n;
    logic        ps_clk;
    logic        ps_sel;
    logic        ps_txd;
    logic        ps_rxd;
    logic        ps_ack_n;
    logic        analog;
    logic [15:0] btn;
    logic [31:0] stick;
    logic [15:0] vib;
    logic        frame_done;

    psx_pad_responder #(
        .ACK_DELAY (ACK_DELAY),
        .ACK_WIDTH (ACK_WIDTH)
    ) dut (
        .I_CLK        (clk),
        .I_RSTn       (rst_n),
        .I_psCLK      (ps_clk),
        .I_psSEL      (ps_sel),
        .I_psTXD      (ps_txd),
        .O_psRXD      (ps_rxd),
        .O_psACK_n    (ps_ack_n),
        .I_ANALOG     (analog),
        .I_BTN        (btn),
        .I_STICK      (stick),
        .O_VIB        (vib),
        .O_FRAME_DONE (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    logic [7:0]  host_b  [9];
    logic [7:0]  exp_rep [9];
    bit          exp_ack [9];
    bit          exp_done;
    logic [15:0] exp_vib_new;
    logic [15:0] exp_vib_reg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level protocol model: reply per byte, ACK per byte, completion.
    task automatic model_frame(input bit an, input int n, input logic [15:0] b,
                               input logic [31:0] s);
        int flen;
        bit dead;
        flen = an ? 9 : 5;
        dead = 1'b0;
        exp_done = 1'b0;
        exp_vib_new = 16'h0;
        for (int i = 0; i < n; i++) begin
            if (dead || i >= flen) begin
                exp_rep[i] = 8'hFF;
                exp_ack[i] = 1'b0;
            end else begin
                case (i)
                    0:       exp_rep[i] = 8'hFF;
                    1:       exp_rep[i] = an ? 8'h73 : 8'h41;
                    2:       exp_rep[i] = 8'h5A;
                    3:       exp_rep[i] = b[7:0];
                    4:       exp_rep[i] = b[15:8];
                    default: exp_rep[i] = s[8*(i-5) +: 8];
                endcase
                if ((i == 0 && host_b[i] != 8'h01) || (i == 1 && host_b[i] != 8'h42))
                    dead = 1'b1;
                exp_ack[i] = !dead && (i != flen - 1);
                if (!dead && i == flen - 1) begin
                    exp_done    = 1'b1;
                    exp_vib_new = {host_b[4], host_b[3]};
                end
            end
        end
    endtask

    task automatic run_frame(input bit an, input int n, input int abort_byte,
                             input int reset_byte, input int chg_byte,
                             input logic [15:0] chg_val, input string nm);
        logic [7:0]  rep;
        logic [15:0] vib_before;
        int          fd0;
        int          cnt;
        bit          dead;
        bit          seen_low;
        analog = an;
        model_frame(an, n, btn, stick);
        fd0 = fd_cnt;
        dead = 1'b0;
        vib_before = vib;
        ps_sel = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rep = 8'h00;
            for (int b = 0; b < 8; b++) begin
                ps_clk = 1'b0;
                ps_txd = host_b[i][b];
                if (i == chg_byte && b == 0) btn = chg_val;
                repeat (HALF) @(negedge clk);
                if (i == reset_byte && b == 4) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    check({nm, "_rst_rxd"}, ps_rxd, 1);
                    check({nm, "_rst_ack"}, ps_ack_n, 1);
                    check({nm, "_rst_vib"}, vib, 0);
                    check({nm, "_rst_fd"},  frame_done, 0);
                    dead = 1'b1;
                    exp_vib_reg = 16'h0;
                end
                rep[b] = ps_rxd;
                ps_clk = 1'b1;
                if (i == abort_byte && b == 2) begin
                    repeat (HALF) @(negedge clk);
                    ps_sel = 1'b1;
                    repeat (3) @(negedge clk);
                    check({nm, "_abort_rxd"}, ps_rxd, 1);
                    check({nm, "_abort_ack"}, ps_ack_n, 1);
                    check({nm, "_abort_vib"}, vib, vib_before);
                    repeat (10) @(negedge clk);
                    check({nm, "_abort_fd"}, fd_cnt - fd0, 0);
                    return;
                end
                if (b < 7) repeat (HALF) @(negedge clk);
            end
            if (i != reset_byte)
                check($sformatf("%s_reply%0d", nm, i), rep, dead ? 8'hFF : exp_rep[i]);
            if (exp_ack[i] && !dead) begin
                cnt = 0;
                do begin
                    @(negedge clk);
                    cnt++;
                end while (ps_ack_n !== 1'b0 && cnt < 400);
                check($sformatf("%s_ackdly%0d", nm, i), cnt, ACK_LAT);
                cnt = 1;
                while (cnt < 400) begin
                    @(negedge clk);
                    if (ps_ack_n === 1'b0) cnt++;
                    else break;
                end
                check($sformatf("%s_ackw%0d", nm, i), cnt, ACK_WIDTH);
            end else begin
                seen_low = 1'b0;
                repeat (200) begin
                    @(negedge clk);
                    if (ps_ack_n !== 1'b1) seen_low = 1'b1;
                end
                check($sformatf("%s_noack%0d", nm, i), seen_low, 0);
            end
        end
        check({nm, "_fdcount"}, fd_cnt - fd0, (exp_done && !dead) ? 1 : 0);
        if (exp_done && !dead) exp_vib_reg = exp_vib_new;
        check({nm, "_vib"}, vib, exp_vib_reg);
        ps_sel = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          an;
        logic [15:0] rb;
        logic [31:0] rs;
        rst_n  = 1'b0;
        ps_clk = 1'b1;
        ps_sel = 1'b1;
        ps_txd = 1'b1;
        analog = 1'b0;
        btn    = 16'hFFFF;
        stick  = 32'h0;
        exp_vib_reg = 16'h0;
        repeat (5) @(negedge clk);
        check("reset_rxd", ps_rxd, 1);
        check("reset_ack", ps_ack_n, 1);
        check("reset_vib", vib, 0);
        check("reset_fd",  frame_done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // psCLK activity with SEL high must do nothing
        repeat (4) begin
            ps_clk = 1'b0; repeat (HALF) @(negedge clk);
            ps_clk = 1'b1; repeat (HALF) @(negedge clk);
        end
        check("selhigh_rxd", ps_rxd, 1);
        check("selhigh_ack", ps_ack_n, 1);

        // Digital poll plus one extra byte clocked after the frame is done
        btn = 16'hFEFF;
        host_b[0] = 8'h01; host_b[1] = 8'h42; host_b[2] = 8'h00;
        host_b[3] = 8'h00; host_b[4] = 8'h00; host_b[5] = 8'h00;
        run_frame(1'b0, 6, NONE, NONE, NONE, 16'h0, "dig");

        // Analog poll with vibration bytes
        stick = 32'h807F10F0;
        btn   = 16'h3CA5;
        host_b[0] = 8'h01; host_b[1] = 8'h42; host_b[2] = 8'h00;
        host_b[3] = 8'hAA; host_b[4] = 8'h55;
        for (int k = 5; k < 9; k++) host_b[k] = 8'h00;
        run_frame(1'b1, 9, NONE, NONE, NONE, 16'h0, "ana");

        // Wrong address byte
        host_b[0] = 8'h81; host_b[3] = 8'h12; host_b[4] = 8'h34;
        run_frame(1'b1, 9, NONE, NONE, NONE, 16'h0, "badaddr");

        // Abort mid byte 3, then a full poll
        btn = 16'hFFFB;
        host_b[0] = 8'h01; host_b[3] = 8'h77; host_b[4] = 8'h66;
        run_frame(1'b0, 5, 3, NONE, NONE, 16'h0, "abort");
        host_b[3] = 8'h0F; host_b[4] = 8'hF0;
        run_frame(1'b0, 5, NONE, NONE, NONE, 16'h0, "after_abort");

        // Buttons change during byte 3; reply must come from the snapshot
        btn = 16'hFFFF;
        host_b[3] = 8'h21; host_b[4] = 8'h43;
        run_frame(1'b0, 5, NONE, NONE, 3, 16'h0000, "snap");

        // Reset pulse during byte 2 with SEL held low
        btn = 16'h1234;
        run_frame(1'b1, 9, NONE, 2, NONE, 16'h0, "midrst");
        host_b[3] = 8'hC3; host_b[4] = 8'h3C;
        run_frame(1'b0, 5, NONE, NONE, NONE, 16'h0, "post_rst");

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            an = 1'($urandom_range(0, 1));
            rb = 16'($urandom);
            rs = $urandom;
            btn   = rb;
            stick = rs;
            for (int k = 0; k < 9; k++) host_b[k] = 8'($urandom);
            host_b[0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h01;
            host_b[1] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h42;
            run_frame(an, an ? 9 : 5, NONE, NONE, NONE, 16'h0, $sformatf("rnd%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
